counting_bloom_filter: RTL and testbench
========================================

COUNTING_BLOOM_FILTER -- requirements
Module: counting_bloom_filter

Interface
REQ-001 Parameter DATA_W, default 32: key width in bits.
REQ-002 Parameter IDX_W, default 5: counter index width; M = 2^IDX_W counters.
REQ-003 Parameter NUM_HASH, default 3, range 1..8: hash functions per key.
REQ-004 Parameter CNT_W, default 4: per-counter width; CMAX = 2^CNT_W-1.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 op_valid  in  1  request present.
REQ-008 op_ready  out  1  block accepts a request this cycle.
REQ-009 op_code  in  2  00 check, 01 insert, 10 delete, 11 clear.
REQ-010 op_data  in  DATA_W  key.
REQ-011 rsp_valid  out  1  one-cycle response strobe.
REQ-012 rsp_match  out  1  all NUM_HASH counters for the key were nonzero.
REQ-013 rsp_err  out  1  overflow (insert) or rejected delete.
REQ-014 elem_count  out  16  net count of successful inserts minus successful deletes.

Function
REQ-015 Hash i (i = 0..NUM_HASH-1): rotate op_data left by 3*i, zero-pad to a multiple of IDX_W, XOR all IDX_W-bit chunks, XOR with i.
REQ-016 FSM states: IDLE, HASH, EXEC, RESP.
REQ-017 op_ready = 1 only in IDLE; a request is accepted when op_valid && op_ready; op_code and op_data are captured on acceptance.
REQ-018 IDLE -> HASH on acceptance; HASH registers all indices; HASH -> EXEC -> RESP -> IDLE, one cycle each.
REQ-019 rsp_valid = 1 exactly in RESP; latency from the accept edge to rsp_valid is 3 cycles; next accept is possible 4 cycles after the previous one.
REQ-020 rsp_match and rsp_err are held valid only while rsp_valid = 1 and are 0 otherwise.
REQ-021 rsp_match is evaluated in EXEC on pre-update counter values, for every op_code except clear, where it is 0.
REQ-022 Check: no state change; rsp_err = 0.
REQ-023 Insert: each distinct index increments once, even if several hashes collide on it; a counter at CMAX stays at CMAX; rsp_err = 1 if any target counter was at CMAX; elem_count increments (saturating at 0xFFFF) regardless of rsp_err.
REQ-024 Delete: applied only if all target counters are nonzero; each distinct non-saturated index decrements once; counters at CMAX are sticky and unchanged; elem_count decrements, floor 0.
REQ-025 Delete with any target counter at zero: no change; rsp_err = 1; rsp_match = 0.
REQ-026 Clear: all M counters and elem_count go to 0 in EXEC; rsp_match = 0; rsp_err = 0.
REQ-027 op_valid while op_ready = 0 is ignored; no queuing.

Reset
REQ-028 reset has priority over every other event: FSM goes to IDLE; all counters, elem_count, rsp_valid, rsp_match and rsp_err go to 0.
REQ-029 op_ready = 1 in the cycle after reset deasserts.
REQ-030 reset mid-operation aborts the operation, produces no response, and applies no partial counter update.

Verification
REQ-031 Check key 0x00000000 after reset -> indices 0, 1, 2; rsp_valid 3 cycles after accept; rsp_match = 0, rsp_err = 0.
REQ-032 Insert 0x00000000, then check it -> counters 0, 1, 2 = 1; rsp_match = 1; elem_count = 1.
REQ-033 Insert 0xFFFFFFFF (indices 3, 2, 1), then delete 0x00000000 -> counters 0 = 0, 1 = 1, 2 = 1, 3 = 1; elem_count = 1; check 0x00000000 -> rsp_match = 0.
REQ-034 Delete 0x00000000 on an empty filter -> rsp_err = 1, rsp_match = 0, counters unchanged, elem_count = 0.
REQ-035 Insert 0x00000000 16 times -> the 16th response has rsp_err = 1 and counters 0..2 = 15; a subsequent delete leaves them at 15.
REQ-036 Reset asserted during EXEC of an insert -> no rsp_valid; all counters 0; op_ready = 1 in the cycle after reset deasserts; clear op -> elem_count = 0.

Source files
------------

// File: rtl/counting_bloom_filter.sv
// Counting Bloom filter with NUM_HASH hash functions over M = 2^IDX_W counters.
// Each accepted request takes four cycles (IDLE accept, HASH, EXEC, RESP) and
// produces a single-cycle response strobe.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   op_valid/ready  - request handshake (ready only while idle)
//   op_code/op_data - 00 check, 01 insert, 10 delete, 11 clear; key
//   rsp_valid       - one-cycle response strobe
//   rsp_match       - all hashed counters were nonzero (pre-update)
//   rsp_err         - insert hit a saturated counter, or delete rejected
//   elem_count      - net successful inserts minus deletes (16-bit, saturating)
module counting_bloom_filter #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned IDX_W    = 5,
   parameter int unsigned NUM_HASH = 3,
   parameter int unsigned CNT_W    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [1:0]        op_code,
   input  logic [DATA_W-1:0] op_data,
   output logic              rsp_valid,
   output logic              rsp_match,
   output logic              rsp_err,
   output logic [15:0]       elem_count
);

   localparam int unsigned M       = 2 ** IDX_W;
   localparam int unsigned N_CHUNK = (DATA_W + IDX_W - 1) / IDX_W;
   localparam int unsigned PAD_W   = N_CHUNK * IDX_W;
   localparam logic [CNT_W-1:0] CMAX = '1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HASH = 2'd1;
   localparam logic [1:0] EXEC = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   localparam logic [1:0] OP_CHECK  = 2'b00;
   localparam logic [1:0] OP_INSERT = 2'b01;
   localparam logic [1:0] OP_DELETE = 2'b10;
   localparam logic [1:0] OP_CLEAR  = 2'b11;

   // Rotate left by 3*i, zero-pad, fold IDX_W-bit chunks with XOR, then XOR in i.
   function automatic logic [IDX_W-1:0] hash_fn(input logic [DATA_W-1:0] d,
                                                 input int unsigned i);
      int unsigned      r;
      logic [DATA_W-1:0] rot;
      logic [PAD_W-1:0]  pad;
      logic [IDX_W-1:0]  h;
      r   = (3 * i) % DATA_W;
      rot = (r == 0) ? d : ((d << r) | (d >> (DATA_W - r)));
      pad = PAD_W'(rot);
      h   = IDX_W'(i);
      for (int unsigned c = 0; c < N_CHUNK; c++) begin
         h = h ^ pad[c*IDX_W +: IDX_W];
      end
      return h;
   endfunction

   logic [1:0]        state, state_n;
   logic [1:0]        code_q;
   logic [DATA_W-1:0] data_q;
   logic [IDX_W-1:0]  idx_q [NUM_HASH];
   logic [CNT_W-1:0]  cnt_q [M];
   logic [CNT_W-1:0]  cnt_n [M];
   logic [M-1:0]      hit;
   logic              any_zero, any_max;
   logic              match_n, err_n;
   logic [15:0]       elem_n;
   logic              accept;

   assign accept = op_valid && op_ready;

   // Next-state logic: one cycle per stage after acceptance.
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (accept) state_n = HASH;
         HASH:    state_n = EXEC;
         EXEC:    state_n = RESP;
         default: state_n = IDLE;
      endcase
   end

   // Counter update for the captured op; colliding hashes map to one hit bit,
   // so each distinct counter moves at most once.
   always_comb begin
      hit      = '0;
      any_zero = 1'b0;
      any_max  = 1'b0;
      for (int unsigned j = 0; j < M; j++) begin
         for (int unsigned i = 0; i < NUM_HASH; i++) begin
            if (idx_q[i] == IDX_W'(j)) hit[j] = 1'b1;
         end
         if (hit[j] && cnt_q[j] == '0) any_zero = 1'b1;
         if (hit[j] && cnt_q[j] == CMAX) any_max = 1'b1;
      end

      match_n = (code_q != OP_CLEAR) && !any_zero;
      err_n   = 1'b0;
      elem_n  = elem_count;
      for (int unsigned j = 0; j < M; j++) cnt_n[j] = cnt_q[j];

      case (code_q)
         OP_INSERT: begin
            err_n = any_max;
            if (elem_count != 16'hFFFF) elem_n = elem_count + 16'd1;
            for (int unsigned j = 0; j < M; j++) begin
               if (hit[j] && cnt_q[j] != CMAX) cnt_n[j] = cnt_q[j] + CNT_W'(1);
            end
         end
         OP_DELETE: begin
            err_n = any_zero;
            if (!any_zero) begin
               if (elem_count != 16'd0) elem_n = elem_count - 16'd1;
               // Saturated counters are sticky: their true count is unknown.
               for (int unsigned j = 0; j < M; j++) begin
                  if (hit[j] && cnt_q[j] != CMAX) cnt_n[j] = cnt_q[j] - CNT_W'(1);
               end
            end
         end
         OP_CLEAR: begin
            elem_n = 16'd0;
            for (int unsigned j = 0; j < M; j++) cnt_n[j] = '0;
         end
         default: ;
      endcase
   end

   // State, capture, index and counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         op_ready   <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_match  <= 1'b0;
         rsp_err    <= 1'b0;
         elem_count <= 16'd0;
         code_q     <= OP_CHECK;
         data_q     <= '0;
         for (int unsigned i = 0; i < NUM_HASH; i++) idx_q[i] <= '0;
         for (int unsigned j = 0; j < M; j++) cnt_q[j] <= '0;
      end else begin
         state     <= state_n;
         op_ready  <= (state_n == IDLE);
         rsp_valid <= (state_n == RESP);
         if (accept) begin
            code_q <= op_code;
            data_q <= op_data;
         end
         if (state == HASH) begin
            for (int unsigned i = 0; i < NUM_HASH; i++) idx_q[i] <= hash_fn(data_q, i);
         end
         if (state == EXEC) begin
            for (int unsigned j = 0; j < M; j++) cnt_q[j] <= cnt_n[j];
            elem_count <= elem_n;
            rsp_match  <= match_n;
            rsp_err    <= err_n;
         end else if (state == RESP) begin
            rsp_match <= 1'b0;
            rsp_err   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_counting_bloom_filter.sv
// Self-checking bench for counting_bloom_filter (default parameters).
// A transaction-level model predicts outputs cycle by cycle; a negedge
// process compares them, and directed steps add literal expectations.
module tb_counting_bloom_filter;

   localparam int DW = 32;
   localparam int IW = 5;
   localparam int NH = 3;
   localparam int M  = 32;
   localparam int CMAX = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic        op_valid;
   logic        op_ready;
   logic [1:0]  op_code;
   logic [31:0] op_data;
   logic        rsp_valid, rsp_match, rsp_err;
   logic [15:0] elem_count;

   int vectors = 0;
   int miscompares = 0;

   counting_bloom_filter dut (
      .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
      .op_code(op_code), .op_data(op_data), .rsp_valid(rsp_valid),
      .rsp_match(rsp_match), .rsp_err(rsp_err), .elem_count(elem_count)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input int got, input int exp);
      vectors++;
      if (got != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
      end
   endfunction

   // ---------------- model ----------------
   int mcnt [M];
   int melem;
   int n = 0;
   int busy_until = 0;
   bit pend_active = 0;
   int pend_due;
   logic [1:0]  pend_code;
   logic [31:0] pend_data;
   bit started = 0;
   bit exp_ready = 1, exp_rv = 0, exp_rm = 0, exp_re = 0;

   // Index i: bit k of the rotated key is key bit (k - 3i) mod DW; it lands in bit k % IW.
   function automatic int mhash(input logic [31:0] d, input int i);
      int r, idx, src;
      r = (3 * i) % DW;
      idx = 0;
      for (int k = 0; k < DW; k++) begin
         src = (k - r + DW) % DW;
         if (d[src]) idx = idx ^ (1 << (k % IW));
      end
      return (idx ^ i) & (M - 1);
   endfunction

   function automatic void model_apply(input logic [1:0] c, input logic [31:0] d,
                                       output bit m, output bit e);
      bit tgt [M];
      bit zero = 0, sat = 0;
      for (int j = 0; j < M; j++) tgt[j] = 0;
      for (int i = 0; i < NH; i++) tgt[mhash(d, i)] = 1;
      for (int j = 0; j < M; j++) begin
         if (tgt[j] && mcnt[j] == 0) zero = 1;
         if (tgt[j] && mcnt[j] == CMAX) sat = 1;
      end
      m = (c != 2'b11) && !zero;
      e = 0;
      case (c)
         2'b01: begin
            e = sat;
            for (int j = 0; j < M; j++) if (tgt[j] && mcnt[j] < CMAX) mcnt[j]++;
            if (melem < 65535) melem++;
         end
         2'b10: begin
            e = zero;
            if (!zero) begin
               for (int j = 0; j < M; j++) if (tgt[j] && mcnt[j] < CMAX) mcnt[j]--;
               if (melem > 0) melem--;
            end
         end
         2'b11: begin
            for (int j = 0; j < M; j++) mcnt[j] = 0;
            melem = 0;
         end
         default: ;
      endcase
   endfunction

   // Model advances on every rising edge, from the inputs that edge samples.
   always @(posedge clk) begin
      bit m, e;
      n++;
      if (reset) begin
         for (int j = 0; j < M; j++) mcnt[j] = 0;
         melem = 0;
         pend_active = 0;
         busy_until = 0;
         exp_ready = 1; exp_rv = 0; exp_rm = 0; exp_re = 0;
         started = 1;
      end else begin
         exp_rv = 0; exp_rm = 0; exp_re = 0;
         if (pend_active && n == pend_due) begin
            model_apply(pend_code, pend_data, m, e);
            exp_rv = 1; exp_rm = m; exp_re = e;
            pend_active = 0;
         end
         if (op_valid && exp_ready) begin
            pend_active = 1;
            pend_due = n + 2;
            pend_code = op_code;
            pend_data = op_data;
            busy_until = n + 3;
         end
         exp_ready = (n >= busy_until);
      end
   end

   // Compare process: every output and counter on every falling edge.
   always @(negedge clk) begin
      if (started) begin
         chk("op_ready", int'(op_ready), int'(exp_ready));
         chk("rsp_valid", int'(rsp_valid), int'(exp_rv));
         chk("rsp_match", int'(rsp_match), int'(exp_rm));
         chk("rsp_err", int'(rsp_err), int'(exp_re));
         chk("elem_count", int'(elem_count), melem);
         for (int j = 0; j < M; j++) chk($sformatf("cnt[%0d]", j), int'(dut.cnt_q[j]), mcnt[j]);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic do_op(input logic [1:0] c, input logic [31:0] d, output bit m, output bit e);
      int t = 0;
      int k = 0;
      while (!op_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t == 20) chk("ready_timeout", 0, 1);
      op_valid = 1'b1; op_code = c; op_data = d;
      m = 0; e = 0;
      while (k < 8) begin
         @(negedge clk);
         k++;
         if (k == 1) op_valid = 1'b0;
         if (rsp_valid) begin
            m = rsp_match; e = rsp_err;
            break;
         end
      end
      chk("latency", k, 3);
      @(negedge clk);
   endtask

   initial begin
      bit m, e;
      reset = 1'b1; op_valid = 1'b0; op_code = 2'b00; op_data = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", int'(op_ready), 1);
      chk("elem_after_reset", int'(elem_count), 0);

      // Pin the model's hash against the documented index sets.
      for (int i = 0; i < NH; i++) chk("mhash_zero", mhash(32'h0, i), i);
      for (int i = 0; i < NH; i++) chk("mhash_ones", mhash(32'hFFFF_FFFF, i), 3 - i);

      // Check on an empty filter.
      do_op(2'b00, 32'h0, m, e);
      chk("chk0_match", int'(m), 0);
      chk("chk0_err", int'(e), 0);

      // Insert 0 then check it.
      do_op(2'b01, 32'h0, m, e);
      do_op(2'b00, 32'h0, m, e);
      chk("ins0_match", int'(m), 1);
      chk("ins0_elem", int'(elem_count), 1);
      for (int j = 0; j < 3; j++) chk("ins0_cnt", int'(dut.cnt_q[j]), 1);

      // Insert all-ones, delete 0.
      do_op(2'b01, 32'hFFFF_FFFF, m, e);
      do_op(2'b10, 32'h0, m, e);
      chk("del_err", int'(e), 0);
      chk("del_cnt0", int'(dut.cnt_q[0]), 0);
      chk("del_cnt1", int'(dut.cnt_q[1]), 1);
      chk("del_cnt2", int'(dut.cnt_q[2]), 1);
      chk("del_cnt3", int'(dut.cnt_q[3]), 1);
      chk("del_elem", int'(elem_count), 1);
      do_op(2'b00, 32'h0, m, e);
      chk("chk_after_del_match", int'(m), 0);

      // Rejected delete on an empty filter.
      do_op(2'b11, 32'h0, m, e);
      chk("clear_match", int'(m), 0);
      chk("clear_err", int'(e), 0);
      do_op(2'b10, 32'h0, m, e);
      chk("rej_err", int'(e), 1);
      chk("rej_match", int'(m), 0);
      chk("rej_elem", int'(elem_count), 0);
      chk("rej_cnt0", int'(dut.cnt_q[0]), 0);

      // Saturation: 16 inserts, then a delete leaves saturated counters alone.
      for (int r = 0; r < 16; r++) begin
         do_op(2'b01, 32'h0, m, e);
         if (r == 14) chk("ins15_err", int'(e), 0);
      end
      chk("ins16_err", int'(e), 1);
      chk("ins16_elem", int'(elem_count), 16);
      for (int j = 0; j < 3; j++) chk("sat_cnt", int'(dut.cnt_q[j]), 15);
      do_op(2'b10, 32'h0, m, e);
      chk("sat_del_err", int'(e), 0);
      chk("sat_del_match", int'(m), 1);
      chk("sat_del_elem", int'(elem_count), 15);
      for (int j = 0; j < 3; j++) chk("sat_del_cnt", int'(dut.cnt_q[j]), 15);

      // op_valid held through a busy window: no queuing, only ready cycles accept.
      op_valid = 1'b1; op_code = 2'b01; op_data = 32'h1234_5678;
      repeat (8) @(negedge clk);
      op_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("held_valid_elem", int'(elem_count), 17);

      // Reset while an insert sits in EXEC.
      op_valid = 1'b1; op_code = 2'b01; op_data = 32'hFFFF_FFFF;
      @(negedge clk);              // accepted; now HASH
      op_valid = 1'b0;
      @(negedge clk);              // now EXEC
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_no_rsp", int'(rsp_valid), 0);
      @(negedge clk);
      chk("rst_ready", int'(op_ready), 1);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      for (int j = 0; j < M; j++) chk("rst_cnt", int'(dut.cnt_q[j]), 0);
      do_op(2'b11, 32'h0, m, e);
      chk("rst_clear_elem", int'(elem_count), 0);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
